// File: rtl/abc2dq.sv
// Forward Clarke + Park transform (a/b phase currents -> alpha/beta -> d/q).
// One shared signed multiplier, sequenced by a six-state FSM; one sample per six cycles.
module abc2dq #(
    parameter int inout_width         = 16,
    parameter int inout_decimal_width = 15
) (
    input  logic                          aclk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [inout_width-1:0] a,
    input  logic signed [inout_width-1:0] b,
    input  logic signed [inout_width-1:0] sin,
    input  logic signed [inout_width-1:0] cos,
    output logic signed [inout_width-1:0] alpha,
    output logic signed [inout_width-1:0] beta,
    output logic signed [inout_width-1:0] d_vector,
    output logic signed [inout_width-1:0] q_vector,
    output logic                          out_valid,
    output logic                          out_sat
);

    localparam int W  = inout_width;
    localparam int F  = inout_decimal_width;
    localparam int OW = W + 2;          // multiplier operand A: holds a + 2*b
    localparam int PW = OW + W;         // full product width
    localparam int AW = 2 * W + 1;      // accumulator width

    localparam int INV_SQRT3_INT = int'(0.5773502692 * (2.0 ** F));
    localparam logic signed [W-1:0]  INV_SQRT3 = W'(INV_SQRT3_INT);
    localparam logic signed [PW-1:0] SAT_MAX   = (PW'(1) <<< (W - 1)) - PW'(1);
    localparam logic signed [PW-1:0] SAT_MIN   = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BETA,
        S_AC,
        S_BS,
        S_BC,
        S_AS
    } state_t;

    function automatic logic is_sat(input logic signed [PW-1:0] x);
        return (x > SAT_MAX) || (x < SAT_MIN);
    endfunction

    function automatic logic signed [W-1:0] sat_val(input logic signed [PW-1:0] x);
        if (x > SAT_MAX) begin
            return SAT_MAX[W-1:0];
        end else if (x < SAT_MIN) begin
            return SAT_MIN[W-1:0];
        end
        return x[W-1:0];
    endfunction

    function automatic logic signed [PW-1:0] scale_acc(input logic signed [AW-1:0] x);
        return $signed({{(PW - AW){x[AW-1]}}, x}) >>> F;
    endfunction

    function automatic logic signed [OW-1:0] ext_op(input logic signed [W-1:0] x);
        return $signed({{2{x[W-1]}}, x});
    endfunction

    state_t               state_q, state_d;
    logic signed [W-1:0]  a_q, a_d, b_q, b_d, sin_q, sin_d, cos_q, cos_d;
    logic signed [W-1:0]  alpha_r_q, alpha_r_d, beta_r_q, beta_r_d;
    logic signed [AW-1:0] acc_dir_q, acc_dir_d, acc_quad_q, acc_quad_d;
    logic                 sat_flag_q, sat_flag_d;
    logic signed [W-1:0]  alpha_q, alpha_d, beta_q, beta_d, d_q, d_d, qv_q, qv_d;
    logic                 out_valid_q, out_valid_d, out_sat_q, out_sat_d;

    logic signed [OW-1:0] sum_ab;
    logic signed [OW-1:0] mul_a;
    logic signed [W-1:0]  mul_b;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_sh;
    logic signed [AW-1:0] prod_acc;
    logic signed [PW-1:0] d_scaled;
    logic signed [PW-1:0] q_scaled;

    // a + 2*b at two extra bits so it can never wrap
    assign sum_ab = ext_op(a_q) + $signed({b_q[W-1], b_q, 1'b0});

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_BETA: begin mul_a = sum_ab;            mul_b = INV_SQRT3; end
            S_AC:   begin mul_a = ext_op(alpha_r_q); mul_b = cos_q;     end
            S_BS:   begin mul_a = ext_op(beta_r_q);  mul_b = sin_q;     end
            S_BC:   begin mul_a = ext_op(beta_r_q);  mul_b = cos_q;     end
            S_AS:   begin mul_a = ext_op(alpha_r_q); mul_b = sin_q;     end
            default: begin mul_a = '0;               mul_b = '0;        end
        endcase
    end

    assign prod     = $signed({{W{mul_a[OW-1]}}, mul_a}) * $signed({{OW{mul_b[W-1]}}, mul_b});
    assign prod_sh  = prod >>> F;
    assign prod_acc = prod[AW-1:0];

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sin_d       = sin_q;
        cos_d       = cos_q;
        alpha_r_d   = alpha_r_q;
        beta_r_d    = beta_r_q;
        acc_dir_d   = acc_dir_q;
        acc_quad_d  = acc_quad_q;
        sat_flag_d  = sat_flag_q;
        alpha_d     = alpha_q;
        beta_d      = beta_q;
        d_d         = d_q;
        qv_d        = qv_q;
        out_valid_d = 1'b0;
        out_sat_d   = out_sat_q;
        d_scaled    = '0;
        q_scaled    = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    sin_d      = sin;
                    cos_d      = cos;
                    sat_flag_d = 1'b0;
                    state_d    = S_BETA;
                end
            end
            S_BETA: begin
                alpha_r_d  = a_q;
                beta_r_d   = sat_val(prod_sh);
                sat_flag_d = sat_flag_q | is_sat(prod_sh);
                state_d    = S_AC;
            end
            S_AC: begin
                acc_dir_d = prod_acc;
                state_d   = S_BS;
            end
            S_BS: begin
                acc_dir_d = acc_dir_q + prod_acc;
                state_d   = S_BC;
            end
            S_BC: begin
                acc_quad_d = prod_acc;
                state_d    = S_AS;
            end
            S_AS: begin
                // final subtraction feeds the output register directly in this cycle
                acc_quad_d  = acc_quad_q - prod_acc;
                d_scaled    = scale_acc(acc_dir_q);
                q_scaled    = scale_acc(acc_quad_d);
                alpha_d     = alpha_r_q;
                beta_d      = beta_r_q;
                d_d         = sat_val(d_scaled);
                qv_d        = sat_val(q_scaled);
                out_sat_d   = sat_flag_q | is_sat(d_scaled) | is_sat(q_scaled);
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sin_q       <= '0;
            cos_q       <= '0;
            alpha_r_q   <= '0;
            beta_r_q    <= '0;
            acc_dir_q   <= '0;
            acc_quad_q  <= '0;
            sat_flag_q  <= 1'b0;
            alpha_q     <= '0;
            beta_q      <= '0;
            d_q         <= '0;
            qv_q        <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sin_q       <= sin_d;
            cos_q       <= cos_d;
            alpha_r_q   <= alpha_r_d;
            beta_r_q    <= beta_r_d;
            acc_dir_q   <= acc_dir_d;
            acc_quad_q  <= acc_quad_d;
            sat_flag_q  <= sat_flag_d;
            alpha_q     <= alpha_d;
            beta_q      <= beta_d;
            d_q         <= d_d;
            qv_q        <= qv_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign alpha     = alpha_q;
    assign beta      = beta_q;
    assign d_vector  = d_q;
    assign q_vector  = qv_q;
    assign out_valid = out_valid_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_abc2dq.sv
// Scoreboard bench for abc2dq: hand-computed vectors are queued at accept time
// and compared by an independent monitor whenever out_valid is seen.
module tb_abc2dq;

    localparam int W = 16;

    logic                aclk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] a, b, sin_in, cos_in;
    logic signed [W-1:0] alpha, beta, d_vector, q_vector;
    logic                out_valid, out_sat;

    abc2dq #(.inout_width(16), .inout_decimal_width(15)) dut (
        .aclk      (aclk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sin       (sin_in),
        .cos       (cos_in),
        .alpha     (alpha),
        .beta      (beta),
        .d_vector  (d_vector),
        .q_vector  (q_vector),
        .out_valid (out_valid),
        .out_sat   (out_sat)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int a, b, s, c;
        int alpha, beta, d, q;
        int sat;
    } vec_t;

    typedef struct {
        int alpha, beta, d, q, sat;
        int acc_cyc;
    } exp_t;

    // a, b, sin, cos -> alpha, beta, d, q, sat (worked by hand)
    vec_t vecs [0:8] = '{
        '{ 16384,  -8192,      0,  32767,  16384,      0,  16383,      0, 0},
        '{ 16384,  -8192,  32767,      0,  16384,      0,      0, -16384, 0},
        '{-32768, -32768,      0,  32767, -32768, -32768, -32767, -32767, 1},
        '{     0,  16384,      0,  32767,      0,  18919,      0,  18918, 0},
        '{     0,  16384,  16384,      0,      0,  18919,   9459,      0, 0},
        '{ 32767,  32767,  32767,  32767,  32767,  32767,  32767,      0, 1},
        '{-16384,      0, -32768, -32768, -16384,  -9460,  25844,  -6924, 0},
        '{-32768,      0, -32768,      0, -32768, -18919,  18919, -32768, 0},
        '{-32768,  16384,      0, -32768, -32768,      0,  32767,      0, 1}
    };

    exp_t sb[$];
    vec_t cur;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   busy    = 0;
    int   accepts = 0;
    int   n_out   = 0;
    int   n_flush = 0;
    bit   prev_ov = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_vec(input int idx);
        cur    = vecs[idx];
        a      = W'(cur.a);
        b      = W'(cur.b);
        sin_in = W'(cur.s);
        cos_in = W'(cur.c);
    endtask

    task automatic send(input int idx);
        set_vec(idx);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (6) step();
    endtask

    always @(posedge aclk) cyc++;

    // Handshake model: predicts in_ready and queues the expected result at accept
    always @(negedge aclk) begin
        exp_t e;
        if (cyc > 0) begin
            chk("in_ready", longint'(in_ready), longint'(busy == 0));
        end
        if (reset) begin
            busy = 0;
        end else if (busy > 0) begin
            busy--;
        end else if (in_valid) begin
            busy      = 5;
            e.alpha   = cur.alpha;
            e.beta    = cur.beta;
            e.d       = cur.d;
            e.q       = cur.q;
            e.sat     = cur.sat;
            e.acc_cyc = cyc + 1;
            sb.push_back(e);
            accepts++;
        end
    end

    // Monitor: pops one expectation per out_valid
    always @(negedge aclk) begin
        exp_t e;
        if (out_valid) begin
            n_out++;
            $display("txn %0d @cyc %0d: alpha=%0d beta=%0d d=%0d q=%0d sat=%0d",
                     n_out, cyc, alpha, beta, d_vector, q_vector, out_sat);
            if (prev_ov) chk("out_valid_width", 2, 1);
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("alpha",   longint'(alpha),    longint'(e.alpha));
                chk("beta",    longint'(beta),     longint'(e.beta));
                chk("d",       longint'(d_vector), longint'(e.d));
                chk("q",       longint'(q_vector), longint'(e.q));
                chk("out_sat", longint'(out_sat),  longint'(e.sat));
                chk("latency", longint'(cyc - e.acc_cyc), 5);
            end
        end
        prev_ov = out_valid;
    end

    initial begin
        int acc0;
        int guard;
        reset    = 1'b1;
        in_valid = 1'b1;
        set_vec(5);
        repeat (3) step();
        chk("rst_alpha",     longint'(alpha),     0);
        chk("rst_beta",      longint'(beta),      0);
        chk("rst_d",         longint'(d_vector),  0);
        chk("rst_q",         longint'(q_vector),  0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_sat",   longint'(out_sat),   0);
        chk("rst_in_ready",  longint'(in_ready),  1);
        reset    = 1'b0;
        in_valid = 1'b0;
        step();

        for (int i = 0; i < 9; i++) send(i);

        // Continuous in_valid with a new sample every cycle
        acc0     = accepts;
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            set_vec(i % 9);
            step();
        end
        in_valid = 1'b0;
        chk("tput_accepts", longint'(accepts - acc0), 5);
        repeat (8) step();

        // Reset while in S_BS aborts the sample
        set_vec(5);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        reset   = 1'b1;
        n_flush += sb.size();
        sb.delete();
        step();
        chk("mid_rst_alpha",    longint'(alpha),    0);
        chk("mid_rst_beta",     longint'(beta),     0);
        chk("mid_rst_d",        longint'(d_vector), 0);
        chk("mid_rst_q",        longint'(q_vector), 0);
        chk("mid_rst_in_ready", longint'(in_ready), 1);
        reset = 1'b0;
        repeat (6) step();
        chk("mid_rst_hold_d", longint'(d_vector), 0);
        send(6);

        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            step();
            guard++;
        end
        chk("sb_drain",  longint'(sb.size()), 0);
        chk("out_count", longint'(n_out), longint'(accepts - n_flush));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
